// File: rtl/b_resp_router_if.sv
// b_resp_router_if: FIFO-front inputs and per-master AXI B channels of b_resp_router
interface b_resp_router_if #(
    parameter int NUM_SLV  = 2,
    parameter int NUM_MST  = 2,
    parameter int ID_WIDTH = 8
);
    localparam int MSEL_W = $clog2(NUM_MST);
    localparam int MID_W  = ID_WIDTH - MSEL_W;
    logic [NUM_SLV-1:0]          fifo_empty;
    logic [NUM_SLV*ID_WIDTH-1:0] fifo_front_BID;
    logic [NUM_SLV*2-1:0]        fifo_front_BRESP;
    logic [NUM_SLV-1:0]          fifo_pop;
    logic [NUM_MST*MID_W-1:0]    BID_M;
    logic [NUM_MST*2-1:0]        BRESP_M;
    logic [NUM_MST-1:0]          BVALID_M;
    logic [NUM_MST-1:0]          BREADY_M;
    logic [NUM_SLV-1:0]          drop_err;
    modport master (
        output fifo_empty, fifo_front_BID, fifo_front_BRESP, BREADY_M,
        input  fifo_pop, BID_M, BRESP_M, BVALID_M, drop_err
    );
    modport slave (
        input  fifo_empty, fifo_front_BID, fifo_front_BRESP, BREADY_M,
        output fifo_pop, BID_M, BRESP_M, BVALID_M, drop_err
    );
endinterface

// File: rtl/b_resp_router.sv
// b_resp_router: round-robin routes per-slave B FIFO fronts to registered per-master B channels
module b_resp_router #(
    parameter int NUM_SLV  = 2,
    parameter int NUM_MST  = 2,
    parameter int ID_WIDTH = 8
) (
    input logic            ACLK,
    input logic            ARESETn,
    b_resp_router_if.slave bus
);
    localparam int MSEL_W = $clog2(NUM_MST);
    localparam int MID_W  = ID_WIDTH - MSEL_W;
    localparam int PTR_W  = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
    logic [MSEL_W-1:0]        tgt [NUM_SLV];
    logic [NUM_SLV-1:0]       req [NUM_MST];
    logic [PTR_W-1:0]         ptr [NUM_MST];
    logic [PTR_W-1:0]         gnt [NUM_MST];
    logic [NUM_MST-1:0]       gv, ld;
    logic [NUM_SLV-1:0]       pop, drop;
    logic [NUM_MST*MID_W-1:0] bid_q;
    logic [NUM_MST*2-1:0]     bresp_q;
    logic [NUM_MST-1:0]       bvalid_q;

    assign ld = ~bvalid_q | bus.BREADY_M;
    assign bus.fifo_pop = ARESETn ? (pop | drop) : '0;
    assign bus.drop_err = ARESETn ? drop : '0;
    assign bus.BID_M    = bid_q;
    assign bus.BRESP_M  = bresp_q;
    assign bus.BVALID_M = bvalid_q;

    always_comb begin
        pop  = '0;
        drop = '0;
        gv   = '0;
        for (int m = 0; m < NUM_MST; m++) begin
            req[m] = '0;
            gnt[m] = '0;
        end
        for (int s = 0; s < NUM_SLV; s++) begin
            tgt[s] = bus.fifo_front_BID[s*ID_WIDTH+MID_W +: MSEL_W];
            if (!bus.fifo_empty[s]) begin
                if (int'(tgt[s]) < NUM_MST) req[tgt[s]][s] = 1'b1;
                else drop[s] = 1'b1;
            end
        end
        // descending scan so the requester closest after ptr is the one left standing
        for (int m = 0; m < NUM_MST; m++)
            for (int k = NUM_SLV - 1; k >= 0; k--)
                if (ld[m] && req[m][(int'(ptr[m]) + k) % NUM_SLV]) begin
                    gv[m]  = 1'b1;
                    gnt[m] = PTR_W'((int'(ptr[m]) + k) % NUM_SLV);
                end
        for (int m = 0; m < NUM_MST; m++)
            if (gv[m]) pop[gnt[m]] = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            bid_q    <= '0;
            bresp_q  <= '0;
            bvalid_q <= '0;
            for (int m = 0; m < NUM_MST; m++) ptr[m] <= '0;
        end else begin
            for (int m = 0; m < NUM_MST; m++) begin
                if (gv[m]) begin
                    bid_q[m*MID_W +: MID_W] <= bus.fifo_front_BID[int'(gnt[m])*ID_WIDTH +: MID_W];
                    bresp_q[m*2 +: 2]       <= bus.fifo_front_BRESP[int'(gnt[m])*2 +: 2];
                    bvalid_q[m]             <= 1'b1;
                    ptr[m]                  <= PTR_W'((int'(gnt[m]) + 1) % NUM_SLV);
                end else if (bvalid_q[m] && bus.BREADY_M[m]) begin
                    bvalid_q[m] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_b_resp_router.sv
// tb_b_resp_router: queue-backed FIFO fronts, per-cycle reference model compare, directed scenarios
module tb_b_resp_router;
    localparam int NS = 2, NM = 2, IW = 8, MW = 7;
    logic ACLK = 1'b0, ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    b_resp_router_if #(.NUM_SLV(NS), .NUM_MST(NM), .ID_WIDTH(IW)) bus2 ();
    b_resp_router_if #(.NUM_SLV(NS), .NUM_MST(3), .ID_WIDTH(IW)) bus3 ();
    b_resp_router #(.NUM_SLV(NS), .NUM_MST(NM), .ID_WIDTH(IW)) u2 (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus2));
    b_resp_router #(.NUM_SLV(NS), .NUM_MST(3), .ID_WIDTH(IW)) u3 (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus3));

    int checks = 0, errors = 0;
    logic [9:0] q0[$], q1[$];
    logic          ev [NM];
    logic [MW-1:0] ebid [NM];
    logic [1:0]    eresp [NM];
    int            last [NM];
    int            g [NM];
    logic [NS-1:0] epop;
    logic [NS-1:0] pop_log[$];
    logic          bv_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] fr(input int s);
        if (s == 0) return q0.size() != 0 ? q0[0] : 10'h0;
        return q1.size() != 0 ? q1[0] : 10'h0;
    endfunction

    function automatic bit emp(input int s);
        return s == 0 ? q0.size() == 0 : q1.size() == 0;
    endfunction

    task automatic drive();
        logic [9:0] e0, e1;
        e0 = fr(0);
        e1 = fr(1);
        bus2.fifo_empty       = {emp(1), emp(0)};
        bus2.fifo_front_BID   = {e1[9:2], e0[9:2]};
        bus2.fifo_front_BRESP = {e1[1:0], e0[1:0]};
    endtask

    task automatic model_check();
        logic [9:0] e;
        int s;
        epop = '0;
        for (int m = 0; m < NM; m++) begin
            g[m] = -1;
            if (ARESETn && (!ev[m] || bus2.BREADY_M[m]))
                for (int k = 1; k <= NS; k++) begin
                    s = (last[m] + k) % NS;
                    e = fr(s);
                    if (g[m] < 0 && !emp(s) && int'(e[9]) == m) g[m] = s;
                end
            if (g[m] >= 0) epop[g[m]] = 1'b1;
        end
        chk("pop", bus2.fifo_pop, epop);
        chk("drop", bus2.drop_err, 0);
        for (int m = 0; m < NM; m++) begin
            chk($sformatf("bvalid%0d", m), bus2.BVALID_M[m], ev[m]);
            chk($sformatf("bid%0d", m), bus2.BID_M[m*MW +: MW], ebid[m]);
            chk($sformatf("bresp%0d", m), bus2.BRESP_M[m*2 +: 2], eresp[m]);
        end
    endtask

    task automatic model_step();
        logic [9:0] e;
        for (int m = 0; m < NM; m++) begin
            if (!ARESETn) begin
                ev[m] = 1'b0; ebid[m] = '0; eresp[m] = '0; last[m] = NS - 1;
            end else if (g[m] >= 0) begin
                e = fr(g[m]);
                ev[m] = 1'b1; ebid[m] = e[8:2]; eresp[m] = e[1:0]; last[m] = g[m];
            end else if (ev[m] && bus2.BREADY_M[m]) ev[m] = 1'b0;
        end
        if (epop[0]) void'(q0.pop_front());
        if (epop[1]) void'(q1.pop_front());
    endtask

    task automatic tick();
        @(negedge ACLK);
        model_check();
        pop_log.push_back(bus2.fifo_pop);
        bv_log.push_back(bus2.BVALID_M[0]);
        @(posedge ACLK);
        model_step();
        #1 drive();
        #1;
    endtask

    int run;
    initial begin
        for (int m = 0; m < NM; m++) begin
            ev[m] = 1'b0; ebid[m] = '0; eresp[m] = '0; last[m] = NS - 1;
        end
        bus2.BREADY_M = 2'b10;
        bus3.fifo_empty = 2'b11; bus3.fifo_front_BID = '0; bus3.fifo_front_BRESP = '0; bus3.BREADY_M = 3'b111;
        q0.push_back({8'h83, 2'b00});
        drive();
        // reset with a non-empty FIFO, then the same entry routes to master 1
        repeat (2) tick();
        chk("t1_pop", bus2.fifo_pop, 0);
        chk("t1_bvalid", bus2.BVALID_M, 0);
        chk("t1_bid", bus2.BID_M, 0);
        ARESETn = 1'b1;
        #1 chk("t2_pop", bus2.fifo_pop, 2'b01);
        tick();
        chk("t2_bvalid", bus2.BVALID_M, 2'b10);
        chk("t2_bid1", bus2.BID_M[MW +: MW], 7'h03);
        chk("t2_bresp1", bus2.BRESP_M[3:2], 0);
        chk("t2_bid0", bus2.BID_M[0 +: MW], 0);
        tick();
        bus2.BREADY_M = 2'b11;
        q0.push_back({8'h01, 2'b00}); q0.push_back({8'h02, 2'b01}); q0.push_back({8'h03, 2'b10});
        q1.push_back({8'h11, 2'b00}); q1.push_back({8'h12, 2'b01}); q1.push_back({8'h13, 2'b10});
        drive();
        pop_log.delete(); bv_log.delete();
        repeat (8) tick();
        for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), pop_log[i], (i % 2) ? 2'b10 : 2'b01);
        chk("t3_idle", pop_log[6], 0);
        run = 0;
        for (int i = 1; i <= 6; i++) run += int'(bv_log[i]);
        chk("t3_bvalid_run", run, 6);
        chk("t3_bvalid_end", bv_log[7], 0);
        bus2.BREADY_M = 2'b10;
        q0.push_back({8'h21, 2'b01}); q0.push_back({8'h22, 2'b10});
        drive();
        tick();
        pop_log.delete(); bv_log.delete();
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_nopop%0d", i), pop_log[i], 0);
            chk($sformatf("t4_hold%0d", i), bv_log[i], 1);
        end
        chk("t4_bid_stable", bus2.BID_M[0 +: MW], 7'h21);
        chk("t4_bresp_stable", bus2.BRESP_M[1:0], 2'b01);
        bus2.BREADY_M = 2'b11;
        #1 chk("t4_nobubble_pop", bus2.fifo_pop, 2'b01);
        tick();
        chk("t4_next_bid", bus2.BID_M[0 +: MW], 7'h22);
        chk("t4_next_bvalid", bus2.BVALID_M[0], 1);
        tick();
        q0.push_back({8'h05, 2'b00}); q1.push_back({8'h86, 2'b11});
        drive();
        #1 chk("t5_pop", bus2.fifo_pop, 2'b11);
        tick();
        chk("t5_bvalid", bus2.BVALID_M, 2'b11);
        chk("t5_bid0", bus2.BID_M[0 +: MW], 7'h05);
        chk("t5_bid1", bus2.BID_M[MW +: MW], 7'h06);
        chk("t5_bresp1", bus2.BRESP_M[3:2], 2'b11);
        tick();
        bus2.BREADY_M = 2'b00;
        q0.push_back({8'h07, 2'b01});
        drive();
        tick();
        chk("rst_pre_bvalid", bus2.BVALID_M[0], 1);
        ARESETn = 1'b0;
        tick();
        chk("rst_mid_bvalid", bus2.BVALID_M, 0);
        ARESETn = 1'b1;
        bus2.BREADY_M = 2'b11;
        tick();
        bus3.fifo_front_BID = 16'h00C5; bus3.fifo_empty = 2'b10;
        #1 chk("t6_pop", bus3.fifo_pop, 2'b01);
        chk("t6_drop", bus3.drop_err, 2'b01);
        tick();
        bus3.fifo_empty = 2'b11;
        #1 chk("t6_drop_pulse", bus3.drop_err, 0);
        chk("t6_no_bvalid", bus3.BVALID_M, 0);
        bus3.fifo_front_BID = 16'h8500; bus3.fifo_front_BRESP = 4'b0100; bus3.fifo_empty = 2'b01;
        #1 chk("t6_m2_pop", bus3.fifo_pop, 2'b10);
        chk("t6_m2_drop", bus3.drop_err, 0);
        tick();
        bus3.fifo_empty = 2'b11;
        #1 chk("t6_m2_bvalid", bus3.BVALID_M, 3'b100);
        chk("t6_m2_bid", bus3.BID_M[12 +: 6], 6'h05);
        chk("t6_m2_bresp", bus3.BRESP_M[5:4], 2'b01);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
